// File: rtl/key_event_queue.sv
// -----------------------------------------------------------------------------
// key_event_queue
//
// Turns four debounced button levels into press/release pulses. It also keeps
// a small queue of button events for a consumer.
//
// - Every press raises an event for that button in a 4-bit pending mask.
// - Each cycle, the lowest-index pending button moves into a 4-deep
//   first-word-fall-through FIFO.
// - The consumer drains the FIFO with a valid/ready handshake.
// - A new event for a button that is still pending is merged (lost). This
//   sets the sticky overflow flag.
//
// Optional feature, macro KEY_EVENT_AUTOREPEAT_EN:
//   A button held down raises repeat events. The first repeat comes
//   REPEAT_DELAY cycles after the press pulse. Further repeats follow every
//   REPEAT_RATE cycles until the button is released.
//   With the macro undefined, only press events enter the queue, and both
//   repeat parameters have no effect.
//
// Ports:
//   clk           - system clock, rising edge
//   reset         - asynchronous active-low reset
//   dataDebounced - [3:0] debounced button levels, 1 = pressed (clk domain)
//   pressPulse    - [3:0] one-cycle pulse per button on a 0->1 change
//   releasePulse  - [3:0] one-cycle pulse per button on a 1->0 change
//   evValid       - FIFO head holds an event
//   evCode        - [1:0] button index of the FIFO head
//   evReady       - consumer accepts the head when evValid is also high
//   overflow      - sticky: at least one event was merged since reset
// -----------------------------------------------------------------------------
module key_event_queue #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dataDebounced,
    output logic [3:0] pressPulse,
    output logic [3:0] releasePulse,
    output logic       evValid,
    output logic [1:0] evCode,
    input  logic       evReady,
    output logic       overflow
);

    logic [3:0] prev;
    logic       arm;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rep_ev;
    logic [3:0] new_ev;

    logic [3:0] pending;
    logic [3:0] pending_nxt;
    logic [3:0] push_mask;
    logic [1:0] push_code;
    logic       push;
    logic       pop;

    logic [1:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    // Edges are detected only once arm is set. The first edge after reset
    // just captures the current levels, so a button held across reset
    // release does not look like a fresh press.
    assign rise   = {4{arm}} & dataDebounced & ~prev;
    assign fall   = {4{arm}} & ~dataDebounced & prev;
    assign new_ev = rise | rep_ev;

    // Choose the lowest-index pending button. Gating push on the count
    // before any pop means a full FIFO never pushes, even in a pop cycle.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_code = 2'd0;
        push_mask = 4'b0000;
        push      = (count != 3'd4) && (pending != 4'b0000);
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                push_code = 2'(i);
                push_mask = 4'b0001 << i;
            end
        end
        if (!push) begin
            push_mask = 4'b0000;
        end
    end

    assign pop = evValid & evReady;

    // A new event only sets a pending bit that was clear before this edge.
    // Because of that, a pending bit is never set and pushed on the same
    // edge. An event whose bit is already pending is dropped here and
    // flagged through overflow.
    assign pending_nxt = (pending & ~push_mask) | (new_ev & ~pending);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev         <= 4'b0000;
            arm          <= 1'b0;
            pressPulse   <= 4'b0000;
            releasePulse <= 4'b0000;
            pending      <= 4'b0000;
            overflow     <= 1'b0;
            wr_ptr       <= 2'd0;
            rd_ptr       <= 2'd0;
            count        <= 3'd0;
            // NOTE: the FIFO storage is reset too, so evCode reads 0 during and after reset; at four 2-bit entries this is plain flops, not a RAM.
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 2'd0;
            end
        end else begin
            prev         <= dataDebounced;
            arm          <= 1'b1;
            pressPulse   <= rise;
            releasePulse <= fall;
            pending      <= pending_nxt;
            if ((new_ev & pending) != 4'b0000) begin
                overflow <= 1'b1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= push_code;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign evValid = (count != 3'd0);
    assign evCode  = fifo_mem[rd_ptr];

`ifdef KEY_EVENT_AUTOREPEAT_EN
    localparam int MAX_INTERVAL = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW           = (MAX_INTERVAL > 1) ? $clog2(MAX_INTERVAL) : 1;
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    // hold_act marks a hold that began with a real press pulse. A button
    // held across reset therefore never auto-repeats. rep_phase tells
    // whether the first repeat has happened yet.
    logic [CW-1:0] hold_cnt [4];
    logic [3:0]    hold_act;
    logic [3:0]    rep_phase;

    always_comb begin
        rep_ev = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rep_ev[i] = hold_act[i] & dataDebounced[i] &
                        (hold_cnt[i] == (rep_phase[i] ? RATE_LAST : DELAY_LAST));
        end
    end

    // The counter is zero on the press edge and counts each held edge after
    // that. It returns to zero on every repeat, so an interval of N cycles
    // ends when the count reaches N-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_act  <= 4'b0000;
            rep_phase <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rise[i] || fall[i]) begin
                    hold_cnt[i]  <= '0;
                    rep_phase[i] <= 1'b0;
                    hold_act[i]  <= rise[i];
                end else if (hold_act[i] && dataDebounced[i]) begin
                    if (rep_ev[i]) begin
                        hold_cnt[i]  <= '0;
                        rep_phase[i] <= 1'b1;
                    end else begin
                        hold_cnt[i] <= hold_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign rep_ev = 4'b0000;
`endif

endmodule

// File: tb/tb_key_event_queue.sv
// -----------------------------------------------------------------------------
// tb_key_event_queue
//
// Self-checking bench for key_event_queue. It has two layers of checks:
// - Table vectors and hand-written sequences with fixed expected values.
// - A queue-based reference model. It advances in lockstep with every clock
//   step and is compared on every cycle, including the randomized run.
//
// Compile with or without KEY_EVENT_AUTOREPEAT_EN. The expectations follow
// the same macro.
// -----------------------------------------------------------------------------
module tb_key_event_queue;

    localparam int DLY  = 10;
    localparam int RATE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dataDebounced;
    logic [3:0] pressPulse;
    logic [3:0] releasePulse;
    logic       evValid;
    logic [1:0] evCode;
    logic       evReady;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    key_event_queue #(
        .REPEAT_DELAY(DLY),
        .REPEAT_RATE (RATE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dataDebounced(dataDebounced),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .evValid      (evValid),
        .evCode       (evCode),
        .evReady      (evReady),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model works from the behavioural rules directly:
    // - pending is a set of buttons and the FIFO is an SV queue;
    // - auto-repeat timing uses the number of edges elapsed since the press.
    bit [3:0] m_prev, m_press, m_rel, m_pend;
    bit       m_arm, m_ovf;
    int       m_q[$];
    int       m_hold[4];   // edges since the press edge, -1 when not in a press hold

    function automatic void model_reset();
        m_prev = 4'b0; m_press = 4'b0; m_rel = 4'b0; m_pend = 4'b0;
        m_arm = 1'b0; m_ovf = 1'b0;
        m_q.delete();
        for (int i = 0; i < 4; i++) m_hold[i] = -1;
    endfunction

    function automatic void model_step(input bit [3:0] d, input bit r);
        bit [3:0] rise, fall, rep, ev, newp;
        int  idx;
        bit  pop;
        rise = m_arm ? (d & ~m_prev) : 4'b0;
        fall = m_arm ? (~d & m_prev) : 4'b0;
        rep  = 4'b0;
`ifdef KEY_EVENT_AUTOREPEAT_EN
        for (int i = 0; i < 4; i++) begin
            if (rise[i]) m_hold[i] = 0;
            else if (fall[i]) m_hold[i] = -1;
            else if (m_hold[i] >= 0 && d[i]) begin
                m_hold[i]++;
                if (m_hold[i] == DLY || (m_hold[i] > DLY && (m_hold[i] - DLY) % RATE == 0))
                    rep[i] = 1'b1;
            end
        end
`endif
        ev  = rise | rep;
        idx = -1;
        if (m_q.size() < 4)
            for (int i = 0; i < 4; i++)
                if (m_pend[i] && idx < 0) idx = i;
        pop = (m_q.size() != 0) && r;
        if ((ev & m_pend) != 4'b0) m_ovf = 1'b1;
        newp = m_pend;
        if (idx >= 0) newp[idx] = 1'b0;
        m_pend = newp | (ev & ~m_pend);
        if (pop) void'(m_q.pop_front());
        if (idx >= 0) m_q.push_back(idx);
        m_press = rise;
        m_rel   = fall;
        m_prev  = d;
        m_arm   = 1'b1;
    endfunction

    task automatic compare_model();
        check("model press", pressPulse, m_press);
        check("model release", releasePulse, m_rel);
        check("model evValid", evValid, m_q.size() != 0);
        check("model overflow", overflow, m_ovf);
        if (m_q.size() != 0) check("model evCode", evCode, m_q[0]);
    endtask

    // Drive one cycle of inputs, step the model, then sample 1 ns after the edge.
    task automatic step(input logic [3:0] d, input logic r);
        dataDebounced = d;
        evReady       = r;
        model_step(d, r);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Assert reset mid-cycle and check the asynchronous clear. Then release
    // reset on a falling edge while holding the given input levels.
    task automatic do_reset(input logic [3:0] d);
        @(negedge clk);
        dataDebounced = d;
        reset = 1'b0;
        #1;
        check("reset pressPulse", pressPulse, 4'b0);
        check("reset releasePulse", releasePulse, 4'b0);
        check("reset evValid", evValid, 1'b0);
        check("reset evCode", evCode, 2'd0);
        check("reset overflow", overflow, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] d;
        logic       r;
        logic [3:0] press;
        logic [3:0] rel;
        logic       valid;
        logic [1:0] code;
        logic       ovf;
    } vec_t;

    vec_t tbl[15];
    int   hits[$];
    int   exp_hits[$];
    int   n;

    initial begin
        reset = 1'b0;
        dataDebounced = 4'b0;
        evReady = 1'b0;
        model_reset();

        // Single press of button 2, then a three-button press drained in index order.
        tbl[0]  = '{4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{4'h4, 1'b1, 4'h4, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{4'h4, 1'b1, 4'h0, 4'h0, 1'b1, 2'd2, 1'b0};
        tbl[4]  = '{4'h4, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{4'h0, 1'b1, 4'h0, 4'h4, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{4'hB, 1'b0, 4'hB, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{4'hB, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0};
        tbl[9]  = '{4'hB, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0};
        tbl[10] = '{4'hB, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0};
        tbl[11] = '{4'hB, 1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 1'b0};
        tbl[12] = '{4'hB, 1'b1, 4'h0, 4'h0, 1'b1, 2'd3, 1'b0};
        tbl[13] = '{4'hB, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{4'h0, 1'b1, 4'h0, 4'hB, 1'b0, 2'd0, 1'b0};

        do_reset(4'h0);
        for (int k = 0; k < 15; k++) begin
            step(tbl[k].d, tbl[k].r);
            check($sformatf("vec%0d press", k), pressPulse, tbl[k].press);
            check($sformatf("vec%0d release", k), releasePulse, tbl[k].rel);
            check($sformatf("vec%0d evValid", k), evValid, tbl[k].valid);
            check($sformatf("vec%0d overflow", k), overflow, tbl[k].ovf);
            if (tbl[k].valid) check($sformatf("vec%0d evCode", k), evCode, tbl[k].code);
        end

        // Overflow: five presses of button 0 with no consumer, then a sixth.
        do_reset(4'h0);
        step(4'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(4'h1, 1'b0);
            step(4'h0, 1'b0);
        end
        check("ovf after 5 presses", overflow, 1'b0);
        check("full head valid", evValid, 1'b1);
        check("full head code", evCode, 2'd0);
        step(4'h1, 1'b0);
        check("ovf after 6th press", overflow, 1'b1);
        step(4'h0, 1'b0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (evValid) begin
                n++;
                check("drain code", evCode, 2'd0);
            end
            step(4'h0, 1'b1);
        end
        check("drain event count", n, 5);
        check("ovf sticky after drain", overflow, 1'b1);

        // Buttons held across reset release: no press pulses, no events.
        do_reset(4'hF);
        for (int c = 0; c < 5; c++) begin
            step(4'hF, 1'b1);
            check("held-reset press", pressPulse, 4'h0);
            check("held-reset evValid", evValid, 1'b0);
        end
        step(4'h0, 1'b1);
        check("held-reset release", releasePulse, 4'hF);

        // Reset in the middle of operation discards queued and pending events.
        do_reset(4'h0);
        step(4'h0, 1'b0);
        step(4'h5, 1'b0);
        step(4'h5, 1'b0);
        check("pre-reset queued", evValid, 1'b1);
        do_reset(4'h5);
        for (int c = 0; c < 4; c++) begin
            step(4'h5, 1'b1);
            check("post-reset evValid", evValid, 1'b0);
        end

        // Hold button 1 for 30 cycles and record the steps where its event is at the head.
        do_reset(4'h0);
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        hits.delete();
        for (int t = 0; t < 35; t++) begin
            step((t < 30) ? 4'h2 : 4'h0, 1'b1);
            if (evValid && evCode == 2'd1) hits.push_back(t);
        end
`ifdef KEY_EVENT_AUTOREPEAT_EN
        exp_hits = '{1, 1 + DLY, 1 + DLY + RATE, 1 + DLY + 2 * RATE, 1 + DLY + 3 * RATE, 1 + DLY + 4 * RATE};
`else
        exp_hits = '{1};
`endif
        check("repeat event count", hits.size(), exp_hits.size());
        for (int k = 0; k < exp_hits.size() && k < hits.size(); k++)
            check($sformatf("repeat event %0d step", k), hits[k], exp_hits[k]);

        // Randomized run against the model, with an occasional reset.
        do_reset(4'h0);
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] d;
            if ($urandom_range(0, 399) == 0) begin
                do_reset(4'($urandom_range(0, 15)));
            end
            d = dataDebounced;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) d[i] = ~d[i];
            step(d, ((c / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 The block SHALL have parameter REPEAT_DELAY, default 25000000, meaning hold cycles from press event to first repeat event.
REQ-002 The block SHALL have parameter REPEAT_RATE, default 5000000, meaning cycles between subsequent repeat events.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port dataDebounced, input, 4 bits, debounced button levels, 1 = pressed, already synchronous to clk.
REQ-006 The block SHALL have port pressPulse, output, 4 bits, one-cycle pulse per button on press.
REQ-007 The block SHALL have port releasePulse, output, 4 bits, one-cycle pulse per button on release.
REQ-008 The block SHALL have port evValid, output, 1 bit, meaning the queue head event is available.
REQ-009 The block SHALL have port evCode, output, 2 bits, the button index of the head event.
REQ-010 The block SHALL have port evReady, input, 1 bit, consumer accept; transfer when evValid and evReady are both high at a clock edge.
REQ-011 The block SHALL have port overflow, output, 1 bit, a sticky flag meaning an event was merged (lost).

Function
REQ-012 An internal register prev SHALL hold the dataDebounced value sampled at the previous edge.
REQ-013 If bit i is sampled 1 at edge n and prev[i]=0, then pressPulse[i] SHALL be high from edge n to edge n+1 (registered, one cycle); releasePulse is symmetric for 1->0.
REQ-014 An arm flag SHALL be 0 after reset; the first edge after reset release only loads prev and sets arm; no pulses or events occur on that edge.
REQ-015 Each press event, and each repeat event (REQ-022), SHALL set pending[i] in a 4-bit pending mask.
REQ-016 If pending[i] is already set, or already being set, when a new event for i arrives, the event SHALL merge and overflow SHALL set to 1 until reset.
REQ-017 Each edge, if the FIFO count < 4 and pending != 0, the block SHALL push the lowest-index pending bit into the FIFO and clear that bit; one push per cycle maximum.
REQ-018 A pending bit set and pushed in the same cycle is not possible: a new event SHALL be pushable no earlier than the edge after it sets pending, giving 2 cycles of latency from input edge to evValid.
REQ-019 The FIFO SHALL have depth 4, be first-word-fall-through, and keep a count of 0..4; evValid = (count != 0), and evCode = head entry.
REQ-020 On simultaneous pop and push, count SHALL stay unchanged; push is gated by count < 4 evaluated before the pop (full plus pop gives no push that cycle).
REQ-021 While evValid=1 and evReady=0, evCode SHALL be held stable; evReady with evValid=0 SHALL be ignored.

Configuration
REQ-022 With KEY_EVENT_AUTOREPEAT_EN defined, each button SHALL have a hold counter: cleared on press or release; while held, a repeat event SHALL be raised REPEAT_DELAY cycles after the press pulse and then every REPEAT_RATE cycles, until release.
REQ-023 Without KEY_EVENT_AUTOREPEAT_EN, no hold counters SHALL exist, only press events SHALL enter the queue, and REPEAT_DELAY/REPEAT_RATE SHALL be unused.

Reset
REQ-024 When reset=0, the block SHALL immediately clear pressPulse, releasePulse, evValid, overflow, pending, count, FIFO pointers, prev, arm, and the hold counters; evCode SHALL read 0.
REQ-025 A reset asserted mid-operation SHALL discard all queued and pending events; a button held across reset release SHALL produce no press event (REQ-014).

Verification
REQ-026 Reset release, then dataDebounced=4'b0100 after 2 cycles, evReady=1 -> pressPulse=4'b0100 for 1 cycle; evValid for 1 cycle with evCode=2; overflow=0.
REQ-027 dataDebounced 0000->1011 in one cycle, evReady=0 -> count reaches 3 over 3 cycles; after evReady=1, codes are popped in order 0, 1, 3.
REQ-028 evReady=0, and 5 separate press/release cycles of button 0 -> the FIFO holds 4 code-0 entries and pending[0]=1; a 6th press sets overflow=1; draining yields 5 events.
REQ-029 dataDebounced=4'b1111 held during reset release -> no pulses and evValid stays 0.
REQ-030 With the macro defined, REPEAT_DELAY=10, REPEAT_RATE=4, button 1 held 30 cycles -> evCode=1 events at press, +10, +14, +18, +22, +26; with the macro undefined -> one event only.
